// File: rtl/motor_seq_ctrl.sv
// Stepper sequencing controller: STEP pulse generation with a linear period ramp and a
// dead-time before direction reversal. Optional step-position counter via MOTOR_SEQ_POS_EN.
module motor_seq_ctrl #(
    parameter int PW        = 16,
    parameter int START_PER = 200,
    parameter int MIN_PER   = 50,
    parameter int RAMP_DEC  = 10,
    parameter int PULSE_W   = 4,
    parameter int DEAD_CYC  = 20
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        EN_REQ,
    input  logic        DIR_REQ,
    input  logic        SW,
    output logic        STEP,
    output logic        DIR,
    output logic        EN,
    output logic        BUSY,
`ifdef MOTOR_SEQ_POS_EN
    output logic [15:0] POS,
`endif
    output logic [2:0]  STATE
);

    // state     | meaning
    // IDLE      | driver disabled, waiting for a run request
    // DEAD      | driver enabled, no steps, direction settling
    // RAMP_UP   | stepping, period shrinking toward MIN_PER
    // RUN       | stepping at MIN_PER
    // RAMP_DOWN | stepping, period growing toward START_PER
    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_DEAD      = 3'd1,
        S_RAMP_UP   = 3'd2,
        S_RUN       = 3'd3,
        S_RAMP_DOWN = 3'd4
    } state_t;

    localparam logic [PW-1:0] START_C = PW'(START_PER);
    localparam logic [PW-1:0] PULSE_C = PW'(PULSE_W);
    localparam logic [PW-1:0] ONE_C   = PW'(1);
    localparam logic [PW-1:0] DEAD_LD = PW'((DEAD_CYC > 0) ? DEAD_CYC - 1 : 0);
    localparam logic [PW:0]   START_X = (PW+1)'(START_PER);
    localparam logic [PW:0]   MIN_X   = (PW+1)'(MIN_PER);
    localparam logic [PW:0]   DEC_X   = (PW+1)'(RAMP_DEC);

    state_t        state_q, state_d;
    logic [PW-1:0] per_q, per_d;
    logic [PW-1:0] cnt_q, cnt_d;
    logic [PW-1:0] dead_q, dead_d;
    logic          step_q, step_d;
    logic          dir_q, dir_d;
    logic          en_q, en_d;

    logic [PW:0]   per_x, per_dn_x, per_up_x;
    logic          boundary, ramp_done, keep_going;

    // Period math one bit wider so the ramp-down sum cannot wrap before the compare.
    always_comb begin
        per_x      = {1'b0, per_q};
        per_dn_x   = (per_x >= MIN_X + DEC_X) ? (per_x - DEC_X) : MIN_X;
        per_up_x   = per_x + DEC_X;
        ramp_done  = (per_up_x >= START_X);
        boundary   = (cnt_q == per_q - ONE_C);
        keep_going = EN_REQ && (DIR_REQ == dir_q);
    end

    always_comb begin
        state_d = state_q;
        per_d   = per_q;
        cnt_d   = cnt_q;
        dead_d  = dead_q;
        step_d  = 1'b0;
        dir_d   = dir_q;
        en_d    = en_q;

        if (SW) begin
            state_d = S_IDLE;
            en_d    = 1'b0;
            cnt_d   = '0;
            per_d   = START_C;
        end else begin
            case (state_q)
                S_IDLE: begin
                    en_d  = 1'b0;
                    cnt_d = '0;
                    if (EN_REQ) begin
                        en_d  = 1'b1;
                        per_d = START_C;
                        if (DIR_REQ == dir_q) begin
                            state_d = S_RAMP_UP;
                        end else begin
                            dir_d   = DIR_REQ;
                            dead_d  = DEAD_LD;
                            state_d = S_DEAD;
                        end
                    end
                end
                S_DEAD: begin
                    if (dead_q == '0) begin
                        state_d = S_RAMP_UP;
                        cnt_d   = '0;
                        per_d   = START_C;
                    end else begin
                        dead_d = dead_q - ONE_C;
                    end
                end
                S_RAMP_UP, S_RUN, S_RAMP_DOWN: begin
                    step_d = (cnt_q < PULSE_C);
                    cnt_d  = boundary ? '0 : (cnt_q + ONE_C);
                    if (boundary) begin
                        case (state_q)
                            S_RAMP_UP: begin
                                if (!keep_going) begin
                                    state_d = S_RAMP_DOWN;
                                end else begin
                                    per_d = per_dn_x[PW-1:0];
                                    if (per_dn_x == MIN_X) state_d = S_RUN;
                                end
                            end
                            S_RUN: begin
                                if (!keep_going) state_d = S_RAMP_DOWN;
                            end
                            default: begin
                                if (ramp_done) begin
                                    per_d = START_C;
                                    if (EN_REQ && (DIR_REQ != dir_q)) begin
                                        dir_d   = DIR_REQ;
                                        dead_d  = DEAD_LD;
                                        state_d = S_DEAD;
                                    end else begin
                                        en_d    = 1'b0;
                                        state_d = S_IDLE;
                                    end
                                end else if (keep_going) begin
                                    state_d = S_RAMP_UP;
                                end else begin
                                    per_d = per_up_x[PW-1:0];
                                end
                            end
                        endcase
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    en_d    = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= S_IDLE;
            per_q   <= START_C;
            cnt_q   <= '0;
            dead_q  <= '0;
            step_q  <= 1'b0;
            dir_q   <= 1'b0;
            en_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            per_q   <= per_d;
            cnt_q   <= cnt_d;
            dead_q  <= dead_d;
            step_q  <= step_d;
            dir_q   <= dir_d;
            en_q    <= en_d;
        end
    end

`ifdef MOTOR_SEQ_POS_EN
    logic [15:0] pos_q, pos_d;

    // Counted on the cycle STEP rises; SW does not clear it.
    always_comb begin
        pos_d = pos_q;
        if (step_d && !step_q) pos_d = pos_q + (dir_q ? 16'd1 : 16'hFFFF);
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) pos_q <= '0;
        else     pos_q <= pos_d;
    end

    assign POS = pos_q;
`endif

    assign STEP  = step_q;
    assign DIR   = dir_q;
    assign EN    = en_q;
    assign BUSY  = (state_q != S_IDLE);
    assign STATE = state_q;

endmodule

// File: tb/tb_motor_seq_ctrl.sv
// Self-checking bench for motor_seq_ctrl: directed ramp/dead-time/stop/reset scenarios, then
// random request traffic against a procedural reference model. Honours MOTOR_SEQ_POS_EN.
module tb_motor_seq_ctrl;

    localparam int PW        = 16;
    localparam int START_PER = 200;
    localparam int MIN_PER   = 50;
    localparam int RAMP_DEC  = 10;
    localparam int PULSE_W   = 4;
    localparam int DEAD_CYC  = 20;

    logic clk = 1'b0;
    logic rst;
    logic en_req, dir_req, sw;
    logic step, dir, en, busy;
    logic [2:0] state;
`ifdef MOTOR_SEQ_POS_EN
    logic [15:0] pos;
`endif

    motor_seq_ctrl #(
        .PW(PW), .START_PER(START_PER), .MIN_PER(MIN_PER),
        .RAMP_DEC(RAMP_DEC), .PULSE_W(PULSE_W), .DEAD_CYC(DEAD_CYC)
    ) dut (
        .CLK(clk), .RST(rst), .EN_REQ(en_req), .DIR_REQ(dir_req), .SW(sw),
        .STEP(step), .DIR(dir), .EN(en), .BUSY(busy),
`ifdef MOTOR_SEQ_POS_EN
        .POS(pos),
`endif
        .STATE(state)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int rises[$];
    bit prev_step = 1'b0;
    bit rose      = 1'b0;

    // Reference model: mode numbers are the documented STATE codes.
    int m_state, m_per, m_ph, m_dead_left;
    bit m_dir, m_en, m_step;
`ifdef MOTOR_SEQ_POS_EN
    int m_pos;
`endif

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d got=%0h expected=%0h", tag, cyc, got, exp);
        end
    endtask

    task automatic model_reset();
        m_state = 0; m_per = START_PER; m_ph = 0; m_dead_left = 0;
        m_dir = 0; m_en = 0; m_step = 0;
`ifdef MOTOR_SEQ_POS_EN
        m_pos = 0;
`endif
    endtask

    task automatic model_boundary(input bit er, input bit dr);
        bit keep;
        keep = er && (dr == m_dir);
        if (m_state == 2) begin
            if (!keep) m_state = 4;
            else begin
                m_per = (m_per - RAMP_DEC < MIN_PER) ? MIN_PER : m_per - RAMP_DEC;
                if (m_per == MIN_PER) m_state = 3;
            end
        end else if (m_state == 3) begin
            if (!keep) m_state = 4;
        end else begin
            if (m_per + RAMP_DEC >= START_PER) begin
                m_per = START_PER;
                if (er && dr != m_dir) begin
                    m_dir = dr; m_state = 1; m_dead_left = DEAD_CYC;
                end else begin
                    m_en = 0; m_state = 0;
                end
            end else if (keep) m_state = 2;
            else m_per = m_per + RAMP_DEC;
        end
    endtask

    task automatic model_tick(input bit er, input bit dr, input bit s);
        bit st;
        if (s) begin
            m_state = 0; m_step = 0; m_en = 0; m_ph = 0; m_per = START_PER;
        end else if (m_state == 0) begin
            m_step = 0;
            if (er) begin
                m_en = 1; m_per = START_PER; m_ph = 0;
                if (dr == m_dir) m_state = 2;
                else begin m_dir = dr; m_state = 1; m_dead_left = DEAD_CYC; end
            end
        end else if (m_state == 1) begin
            m_step = 0;
            m_dead_left--;
            if (m_dead_left == 0) begin m_state = 2; m_ph = 0; m_per = START_PER; end
        end else begin
            st = (m_ph < PULSE_W);
`ifdef MOTOR_SEQ_POS_EN
            if (st && !m_step) m_pos = m_pos + (m_dir ? 1 : -1);
`endif
            m_step = st;
            if (m_ph == m_per - 1) begin
                m_ph = 0;
                model_boundary(er, dr);
            end else m_ph++;
        end
    endtask

    // Advance one clock: model uses the inputs the DUT will sample, compare at the negedge.
    task automatic cycle();
        model_tick(en_req, dir_req, sw);
        @(negedge clk);
        cyc++;
        chk("step", step, m_step);
        chk("dir", dir, m_dir);
        chk("en", en, m_en);
        chk("busy", busy, (m_state != 0));
        chk("state", state, m_state);
`ifdef MOTOR_SEQ_POS_EN
        chk("pos", pos, m_pos & 32'hFFFF);
`endif
        rose = step && !prev_step;
        if (rose) rises.push_back(cyc);
        prev_step = step;
    endtask

    task automatic async_reset();
        #2 rst = 1'b1;
        #1;
        chk("arst_step", step, 0);
        chk("arst_dir", dir, 0);
        chk("arst_en", en, 0);
        chk("arst_busy", busy, 0);
        chk("arst_state", state, 0);
`ifdef MOTOR_SEQ_POS_EN
        chk("arst_pos", pos, 0);
`endif
        model_reset();
        prev_step = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic wait_state(input int s, input int budget, input string tag);
        int n = 0;
        while (state != 3'(s) && n < budget) begin cycle(); n++; end
        chk(tag, state, s);
    endtask

    task automatic wait_rises(input int want, input int budget, input string tag);
        int c = 0, k = 0;
        while (c < want && k < budget) begin cycle(); if (rose) c++; k++; end
        chk(tag, c, want);
    endtask

    function automatic int spacing(input int i);
        return (rises.size() > i + 1) ? rises[i+1] - rises[i] : -1;
    endfunction

    initial begin
        int dead_n, hi_n, sw_left;
        rst = 1'b1; en_req = 0; dir_req = 0; sw = 0;
        model_reset();
        repeat (3) @(negedge clk);
        chk("rst_step", step, 0);
        chk("rst_en", en, 0);
        chk("rst_dir", dir, 0);
        chk("rst_busy", busy, 0);
        chk("rst_state", state, 0);
        rst = 1'b0;

        // Ramp up to cruise
        en_req = 1; dir_req = 0;
        rises.delete();
        wait_state(3, 5000, "up_reach_run");
        repeat (120) cycle();
        chk("up_nrises", rises.size() >= 18, 1);
        for (int i = 0; i < 15; i++) chk("up_space", spacing(i), 200 - 10 * i);
        chk("run_space0", spacing(15), 50);
        chk("run_space1", spacing(16), 50);
        chk("run_en", en, 1);
        chk("run_dir", dir, 0);

        // Ramp down to idle
        en_req = 0;
        rises.delete();
        wait_state(0, 5000, "dn_reach_idle");
        chk("dn_nrises", rises.size(), 15);
        for (int i = 0; i < 14; i++) chk("dn_space", spacing(i), 50 + 10 * i);
        chk("dn_en", en, 0);
        chk("dn_busy", busy, 0);
        chk("dn_step", step, 0);

        // Reversal through dead-time
        en_req = 1; dir_req = 0;
        wait_state(3, 5000, "rev_reach_run");
        dir_req = 1;
        wait_state(1, 5000, "rev_reach_dead");
        dead_n = 0;
        while (state == 3'd1 && dead_n < 100) begin
            chk("dead_step", step, 0);
            chk("dead_en", en, 1);
            chk("dead_dir", dir, 1);
            dead_n++;
            cycle();
        end
        chk("dead_len", dead_n, DEAD_CYC);
        chk("dead_exit", state, 2);
        rises.delete();
        repeat (400) cycle();
        chk("rev_space0", spacing(0), 200);

        // Manual stop mid-pulse
        wait_state(3, 5000, "sw_reach_run");
        hi_n = 0;
        while (!step && hi_n < 100) begin cycle(); hi_n++; end
        chk("sw_midpulse", step, 1);
        sw = 1;
        cycle();
        chk("sw_step", step, 0);
        chk("sw_en", en, 0);
        chk("sw_state", state, 0);
        chk("sw_dir", dir, 1);
        hi_n = 0;
        for (int i = 0; i < 100; i++) begin
            en_req = 1'($urandom_range(0, 1));
            cycle();
            if (step) hi_n++;
        end
        chk("sw_nostep", hi_n, 0);
        sw = 0; en_req = 1; dir_req = 1;
        rises.delete();
        repeat (400) cycle();
        chk("sw_restart_space", spacing(0), 200);

        // Asynchronous reset during ramp-up, then recover
        wait_state(2, 5000, "arst_reach_up");
        repeat (300) cycle();
        async_reset();
        en_req = 1; dir_req = 0;
        rises.delete();
        wait_state(3, 5000, "rec_reach_run");
        chk("rec_nrises", rises.size(), 15);
        chk("rec_space0", spacing(0), 200);

`ifdef MOTOR_SEQ_POS_EN
        async_reset();
        dir_req = 1; en_req = 1; sw = 0;
        wait_rises(20, 8000, "pos_fwd_steps");
        sw = 1; cycle(); sw = 0;
        dir_req = 0;
        wait_rises(5, 8000, "pos_rev_steps");
        sw = 1; cycle();
        chk("pos_net15", pos, 15);
        sw = 0;
        async_reset();
        dir_req = 0; en_req = 1;
        wait_rises(1, 8000, "pos_one_step");
        sw = 1; cycle();
        chk("pos_wrap", pos, 16'hFFFF);
        sw = 0;
`endif

        // Random request traffic
        sw_left = 0;
        for (int i = 0; i < 20000; i++) begin
            if ($urandom_range(0, 299) == 0) en_req = ~en_req;
            if ($urandom_range(0, 399) == 0) dir_req = ~dir_req;
            if (!sw && $urandom_range(0, 1999) == 0) begin
                sw = 1; sw_left = $urandom_range(1, 30);
            end else if (sw) begin
                sw_left--;
                if (sw_left <= 0) sw = 0;
            end
            if ($urandom_range(0, 3999) == 0) async_reset();
            cycle();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/motor_seq_ctrl.md
Name: motor_seq_ctrl

Overview:
Motor sequencing controller that sits downstream of the IR-sensor direction detector. It takes the detector's run request and direction request and drives the stepper driver: it generates STEP pulses with a linear acceleration/deceleration period ramp and inserts a dead-time before any direction reversal. A manual stop switch (SW) overrides everything.

Parameters:
PW, 16, width of period/phase counters
START_PER, 200, step period in CLK cycles at ramp start and ramp end
MIN_PER, 50, cruise step period in CLK cycles
RAMP_DEC, 10, period change per step while ramping
PULSE_W, 4, STEP high time in CLK cycles
DEAD_CYC, 20, dead-time cycles before a direction change

Ports:
CLK  in  1  system clock, rising edge
RST  in  1  asynchronous reset, active-high
EN_REQ  in  1  run request from direction detector (1 = run)
DIR_REQ  in  1  requested direction from direction detector
SW  in  1  manual stop, active-high, overrides EN_REQ
STEP  out  1  step pulse to motor driver (registered)
DIR  out  1  direction to motor driver (registered)
EN  out  1  driver enable (registered)
BUSY  out  1  1 when STATE != IDLE
STATE  out  3  FSM state: IDLE=0, DEAD=1, RAMP_UP=2, RUN=3, RAMP_DOWN=4

Behaviour:
- One clock domain, CLK. RST asynchronous, active-high. On reset: STATE=IDLE, STEP=0, DIR=0, EN=0, BUSY=0, per=START_PER, phase cnt=0, dead cnt=0.
- Legal parameters: PULSE_W < MIN_PER <= START_PER < 2^PW; RAMP_DEC >= 1. Period arithmetic is done at PW+1 bits with saturation: never below MIN_PER, never above START_PER.
- Step timing in RAMP_UP/RUN/RAMP_DOWN: cnt runs 0..per-1. STEP=1 (registered, one cycle after) while cnt < PULSE_W. When cnt==per-1, the step boundary is reached and cnt returns to 0. STEP rising edges are exactly per cycles apart. State and period changes happen only at step boundaries, so a pulse is never truncated except by SW.
- IDLE: EN=0, STEP=0. If EN_REQ=1 and SW=0: EN<=1 and per<=START_PER. If DIR_REQ==DIR, go to RAMP_UP. Otherwise DIR<=DIR_REQ and go to DEAD.
- DEAD: EN=1, STEP=0. Counts DEAD_CYC cycles, then goes to RAMP_UP with cnt=0 and per=START_PER.
- RAMP_UP, at each boundary:
  - If EN_REQ=0 or DIR_REQ!=DIR, go to RAMP_DOWN with per unchanged.
  - Otherwise per<=max(per-RAMP_DEC, MIN_PER). If the new per==MIN_PER, go to RUN.
- RUN, at each boundary: if EN_REQ=0 or DIR_REQ!=DIR, go to RAMP_DOWN. Otherwise stay.
- RAMP_DOWN, at each boundary:
  - If per+RAMP_DEC >= START_PER, the ramp is finished:
    - If EN_REQ=1 and DIR_REQ!=DIR: DIR<=DIR_REQ, per<=START_PER, go to DEAD.
    - Otherwise: EN<=0, per<=START_PER, go to IDLE.
  - Else if EN_REQ=1 and DIR_REQ==DIR, go back to RAMP_UP with per unchanged.
  - Else per<=per+RAMP_DEC.
- SW=1 sampled in any state:
  - Next cycle: STATE=IDLE, STEP=0, EN=0, cnt=0, per=START_PER. DIR holds its value.
  - IDLE is held while SW=1, regardless of EN_REQ.
- DIR changes only on entry to DEAD, never while STEP can be high.
- EN_REQ/DIR_REQ toggling mid-step has no effect until the next boundary.

Optional Feature:
MOTOR_SEQ_POS_EN
- Defined: adds output POS [15:0], a two's-complement step position.
  - Reset to 0.
  - +1 on each STEP rising edge when DIR=1; -1 when DIR=0.
  - Wraps modulo 2^16.
  - Unaffected by SW.
- Not defined: POS port and its counter are absent; all other behaviour is identical.

Test Plan:
1. Reset, then EN_REQ=1, DIR_REQ=0, SW=0 (defaults) -> STATE 0→2. STEP rise-to-rise spacings are 200,190,...,60 (15 steps), then STATE=3 and spacing 50. Each pulse is 4 cycles high. DIR=0, EN=1.
2. From RUN, EN_REQ=0 -> RAMP_DOWN at the next boundary. Spacings are 50,60,...,190 (15 steps), then STATE=0, EN=0, STEP=0, BUSY=0.
3. From RUN at DIR=0, set DIR_REQ=1 and keep EN_REQ=1 -> full ramp down. Then DEAD for 20 cycles with STEP=0, EN=1, DIR=1. Then RAMP_UP begins at period 200.
4. SW=1 asserted mid-pulse in RUN -> next cycle STEP=0, EN=0, STATE=0. Toggling EN_REQ while SW=1 gives no STEP. After SW=0 with EN_REQ=1, the ramp restarts at period 200.
5. RST asserted asynchronously mid-RAMP_UP -> all outputs are 0 immediately, without waiting for a CLK edge. Recovery from IDLE works as in scenario 1.
6. With MOTOR_SEQ_POS_EN: 20 steps at DIR=1, then 5 steps at DIR=0 -> POS=15. Starting from 0 with 1 step at DIR=0 -> POS=16'hFFFF.
